// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle controller.
//   state_t     : 4-bit FSM state encoding (also exposed on the debug port)
//   OP_*        : supported primary opcodes (instruction bits [31:26])
//   ALU_*       : alu_op encodings
//   SRCB_*      : alu_src_b encodings
//   PCSRC_*     : pc_source encodings
//   FAULT_*     : sticky fault codes
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] FAULT_NONE        = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL_OP  = 2'b01;
    localparam logic [1:0] FAULT_MEM_TIMEOUT = 2'b10;

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational control-output decode for the multicycle MIPS controller.
// Ports:
//   state     in  4 : registered FSM state
//   mem_ready in  1 : memory handshake (only used to qualify the FETCH strobes)
//   enable    in  1 : 0 forces every output low (driven by the active-low reset)
//   remaining ports : datapath strobes and mux selects
module mips_mc_outdec
    import mips_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic       enable,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg
);

    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        // Gating here keeps the reset-state FETCH decode from requesting memory.
        if (enable) begin
            case (state_t'(state))
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    // IR and PC load only on the cycle the fetch completes.
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH2;
                end
                S_MEM_ADDR, S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle sequencing controller for a shared-ALU, unified-memory MIPS
// datapath. Holds the state register, next-state logic, memory wait counter
// and sticky fault register; output decode lives in mips_mc_outdec.
// Ports:
//   clk, rst (async active-low), op (instr[31:26]), mem_ready
//   mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
//   pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
//   mem_to_reg : control outputs
//   fault : sticky fault code, state : current FSM state (debug)
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] fault,
    output logic [3:0] state
);

    // Wide enough to hold TIMEOUT with headroom for saturation.
    localparam int              CNT_W     = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           cur;
    state_t           nxt;
    logic [1:0]       fault_code;
    logic             is_store;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             waiting;
    logic             timeout_hit;

    assign state   = cur;
    assign waiting = mem_req && !mem_ready;
    assign cnt_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;
    // Fires on the wait cycle that brings the count to TIMEOUT; a ready
    // in the same cycle clears waiting, so completion wins.
    assign timeout_hit = (TIMEOUT != 0) && waiting && (cnt_inc >= TIMEOUT_C);

    always_comb begin
        nxt        = cur;
        fault_code = FAULT_NONE;
        case (cur)
            S_FETCH:     if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_I_EXEC;
                    default: begin
                        nxt        = S_ILLEGAL;
                        fault_code = FAULT_ILLEGAL_OP;
                    end
                endcase
            end
            S_MEM_ADDR:  nxt = is_store ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) nxt = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) nxt = S_FETCH;
            S_EXEC:      nxt = S_ALU_WB;
            S_I_EXEC:    nxt = S_I_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_I_WB: nxt = S_FETCH;
            S_ILLEGAL:   nxt = S_ILLEGAL;
            default:     nxt = S_FETCH;
        endcase
        if (timeout_hit) begin
            nxt        = S_ILLEGAL;
            fault_code = FAULT_MEM_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= S_FETCH;
            fault    <= FAULT_NONE;
            wait_cnt <= '0;
            is_store <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt == S_ILLEGAL && cur != S_ILLEGAL) begin
                fault <= fault_code;
            end
            // Any state change clears the counter, which covers entry into
            // every memory state.
            if (nxt != cur) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= cnt_inc;
            end
            // op is only valid in DECODE; remember load vs store for MEM_ADDR.
            if (cur == S_DECODE) begin
                is_store <= (op == OP_SW);
            end
        end
    end

    mips_mc_outdec u_outdec (
        .state         (cur),
        .mem_ready     (mem_ready),
        .enable        (rst),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg)
    );

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle sequencing controller for the MIPS datapath. It replaces the single-cycle combinational control decode with a Moore FSM that steps one instruction through fetch, decode, execute, memory and write-back cycles. It drives the strobes and mux selects of a shared-ALU, unified-memory datapath. It also owns the memory handshake, with wait states and a timeout, and latches a sticky fault on an illegal opcode or an unresponsive memory.

## Interface
- `TIMEOUT`, default 16: the maximum number of cycles a memory state waits for `mem_ready` before faulting. A value of 0 disables the timeout.
- `clk` in 1: the only clock. All state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = in reset).
- `op` in 6: instruction `[31:26]`, taken from the instruction register.
- `mem_ready` in 1: memory accepted or completed the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: the request is a write. Meaningful only while `mem_req` = 1.
- `i_or_d` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by the ALU zero flag, for beq.
- `pc_source` out 2: PC input select. 00 = ALU result, 01 = ALUOut, 10 = jump target `{pc[31:28], imm26<<2}`.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = decode from funct.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = register A.
- `alu_src_b` out 2: ALU B select. 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `reg_write` out 1: register file write.
- `reg_dst` out 1: destination register. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back data select. 0 = ALUOut, 1 = MDR.
- `fault` out 2: sticky. 00 = none, 01 = illegal opcode, 10 = memory timeout.
- `state` out 4: current FSM state, for debug and verification.

## Operation
- Supported opcodes:
  - R-type: `000000`
  - lw: `100011`
  - sw: `101011`
  - beq: `000100`
  - j: `000010`
  - addi: `001000`
- States, with 4-bit encodings:
  - FETCH = 0: `mem_req`; `i_or_d` = 0; `alu_src_a` = 0; `alu_src_b` = 01; `alu_op` = 00; `pc_source` = 00. `ir_write` and `pc_write` pulse only in the cycle where `mem_ready` = 1. Go to DECODE on `mem_ready`, otherwise stay.
  - DECODE = 1: `alu_src_a` = 0; `alu_src_b` = 11; `alu_op` = 00 (computes the branch target). Dispatch on `op`:
    - lw or sw → MEM_ADDR
    - R-type → EXEC
    - beq → BRANCH
    - j → JUMP
    - addi → I_EXEC
    - anything else → ILLEGAL, with `fault` = 01.
  - MEM_ADDR = 2: `alu_src_a` = 1; `alu_src_b` = 10; `alu_op` = 00. lw → MEM_READ, sw → MEM_WRITE.
  - MEM_READ = 3: `mem_req`; `i_or_d` = 1. Go to MEM_WB on `mem_ready`.
  - MEM_WB = 4: `reg_write`; `mem_to_reg` = 1; `reg_dst` = 0. Go to FETCH.
  - MEM_WRITE = 5: `mem_req`; `mem_write`; `i_or_d` = 1. Go to FETCH on `mem_ready`.
  - EXEC = 6: `alu_src_a` = 1; `alu_src_b` = 00; `alu_op` = 10. Go to ALU_WB.
  - ALU_WB = 7: `reg_write`; `reg_dst` = 1; `mem_to_reg` = 0. Go to FETCH.
  - BRANCH = 8: `alu_src_a` = 1; `alu_src_b` = 00; `alu_op` = 01; `pc_write_cond`; `pc_source` = 01. Go to FETCH.
  - JUMP = 9: `pc_write`; `pc_source` = 10. Go to FETCH.
  - I_EXEC = 10: `alu_src_a` = 1; `alu_src_b` = 10; `alu_op` = 00. Go to I_WB.
  - I_WB = 11: `reg_write`; `reg_dst` = 0; `mem_to_reg` = 0. Go to FETCH.
  - ILLEGAL = 12: all strobes 0. Terminal; left only by reset.
- Every output not listed for a state is 0.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle that `mem_req` = 1 and `mem_ready` = 0.
  - If `TIMEOUT` ≠ 0 and the counter reaches `TIMEOUT`: go to ILLEGAL with `fault` = 10. `mem_ready` arriving in that same cycle wins.
  - The counter saturates and does not wrap.
- `fault` is written only on the transition into ILLEGAL and holds until reset.

## Timing
- Reset:
  - Asynchronous assertion: `state` = FETCH, `fault` = 00, counter = 0.
  - All outputs are forced to 0 while `rst` = 0, including `mem_req`.
  - The first request is made in the first cycle after release.
- Outputs are a combinational decode of registered state, gated by `mem_ready` only where stated above. There are no output registers.
- Latency with zero wait states (`mem_ready` held at 1):
  - R-type: 4 cycles
  - addi: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - beq: 3 cycles
  - j: 3 cycles
- Each memory wait cycle adds exactly 1 cycle.
- `mem_ready` is ignored in non-memory states.
- `op` is sampled only in DECODE.
- Reset asserted mid-instruction aborts it immediately. No partial write strobe may persist past the asynchronous assertion.

## Structure
- `mips_pkg` holds:
  - the state enum (4-bit)
  - opcode constants
  - `alu_op`, `alu_src_b` and `pc_source` encodings
  - fault codes
- One sub-module, `mips_mc_outdec`: a purely combinational map from state (plus `mem_ready`) to the control outputs. The top level holds the state register, next-state logic, wait counter and fault register.

## Test plan
- R-type with `op` = 0 and `mem_ready` = 1: `state` sequence is 0, 1, 6, 7, 0. `reg_write` = 1 with `reg_dst` = 1 only in cycle 4. `ir_write` fires once.
- lw with `mem_ready` low for 2 cycles in MEM_READ: sequence is 0, 1, 2, 3, 3, 3, 4, 0. `mem_req` with `i_or_d` = 1 for 3 cycles. `mem_to_reg` = 1 in MEM_WB.
- beq, then j: beq gives 0, 1, 8 with `pc_write_cond` = 1, `alu_op` = 01, `pc_source` = 01. j gives 0, 1, 9 with `pc_write` = 1, `pc_source` = 10.
- `op` = `111111`: after DECODE, `state` = 12 and `fault` = 01. It stays in state 12 for 20 or more cycles with all strobes 0. After a `rst` pulse, `state` = 0 and `fault` = 00.
- `TIMEOUT` = 4 with `mem_ready` held at 0 in FETCH: 4 wait cycles, then `state` = 12 and `fault` = 10. Also check `mem_ready` rising exactly on the 4th wait cycle: the FSM goes to DECODE with no fault.
- Reset asserted during MEM_WRITE: `mem_req` and `mem_write` drop with `rst`, before the next clock edge. After release, the first cycle is FETCH.
